// File: rtl/axis_packer.sv
// axis_packer: packs RATIO narrow AXIS beats into one wide word with keep/last; AXIS_PACKER_ZERO_FILL_EN zero-fills unused lanes
module axis_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       s_tdata,
    input  logic                        s_tlast,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    output logic [DATA_WIDTH*RATIO-1:0] m_tdata,
    output logic [RATIO-1:0]            m_tkeep,
    output logic                        m_tlast,
    output logic                        m_tvalid,
    input  logic                        m_tready
);
    localparam int CNT_WIDTH = $clog2(RATIO);
    logic [CNT_WIDTH-1:0]        idx;
    logic [DATA_WIDTH*RATIO-1:0] acc, merged;
    logic [RATIO-1:0]            keep;
    logic                        accept, done;
    assign s_tready = ~m_tvalid | m_tready;
    assign accept   = s_tvalid & s_tready;
    assign done     = accept & (s_tlast | idx == CNT_WIDTH'(RATIO - 1));
    always_comb begin
        merged = acc;
        keep   = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k == int'(idx)) merged[k*DATA_WIDTH +: DATA_WIDTH] = s_tdata;
            keep[k] = k <= int'(idx);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            acc      <= '0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else begin
            if (accept) begin
`ifdef AXIS_PACKER_ZERO_FILL_EN
                acc <= done ? '0 : merged;
`else
                acc <= merged;
`endif
                idx <= done ? '0 : idx + 1'b1;
            end
            if (done) begin
                m_tdata  <= merged;
                m_tkeep  <= keep;
                m_tlast  <= s_tlast;
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
        end
    end
endmodule
